// File: rtl/qbert_jump_engine.sv
// -----------------------------------------------------------------------------
// qbert_jump_engine
//
// Command-driven Q*bert hop animator. A one-cycle jump request with a
// direction moves the sprite anchor through three phases, one pixel per
// animation tick: rise (x decreasing), lateral shift (y toward target), and
// fall (x increasing to target). A single LAND cycle closes each hop.
//
// The jump/done_move pair follows the handshake the cube colour logic
// expects: jump rises as done_move falls on accept, and jump falls as
// done_move rises after LAND, giving exactly one event per completed hop.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   load        load start_xy into the anchor (IDLE only)
//   start_xy    {x[10:0], y[9:0]} value for load
//   req         jump request, sampled in IDLE only
//   dir         bit1: 1 = down (x+TILE_DX), 0 = up (x-TILE_DX)
//               bit0: 1 = left (y-TILE_DY), 0 = right (y+TILE_DY)
//   xy_pos      current anchor {x, y}
//   jump        high from accept through the LAND cycle
//   done_move   high whenever no move is in progress
//   req_ack     one-cycle pulse on an accepted request
//   req_reject  one-cycle pulse when the target falls outside the field
//   land        one-cycle pulse during the LAND cycle
// -----------------------------------------------------------------------------
module qbert_jump_engine #(
  parameter int unsigned STEP_DIV = 131072,
  parameter int unsigned HOP_H    = 10,
  parameter int unsigned TILE_DX  = 180,
  parameter int unsigned TILE_DY  = 100,
  parameter logic [20:0] RESET_XY = {11'd350, 10'd210},
  parameter int          X_MIN    = 0,
  parameter int          X_MAX    = 2047,
  parameter int          Y_MIN    = 0,
  parameter int          Y_MAX    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [20:0] start_xy,
  input  logic        req,
  input  logic [1:0]  dir,
  output logic [20:0] xy_pos,
  output logic        jump,
  output logic        done_move,
  output logic        req_ack,
  output logic        req_reject,
  output logic        land
);

  typedef enum logic [2:0] {IDLE, RISE, SHIFT, FALL, LAND} state_t;

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

  // Target arithmetic is done signed and wider than the coordinates so that
  // under- and overflow show up as out-of-field values instead of wrapping.
  localparam logic signed [12:0] DX_S    = 13'(TILE_DX);
  localparam logic signed [12:0] HOP_S   = 13'(HOP_H);
  localparam logic signed [12:0] XMIN_S  = 13'(X_MIN);
  localparam logic signed [12:0] XMAX_S  = 13'(X_MAX);
  localparam logic signed [11:0] DY_S    = 12'(TILE_DY);
  localparam logic signed [11:0] YMIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S  = 12'(Y_MAX);

  state_t          state_q, state_d;
  logic [10:0]     xc_q, xc_d;
  logic [9:0]      yc_q, yc_d;
  logic [10:0]     tx_q, tx_d;
  logic [9:0]      ty_q, ty_d;
  logic [10:0]     apex_q, apex_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            jump_q, jump_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            rej_q, rej_d;
  logic            land_q, land_d;

  // Candidate target for the current anchor and direction.
  logic signed [12:0] xc_s, tx_w, min_x_w, apex_w;
  logic signed [11:0] yc_s, ty_w;
  logic               legal;
  logic               tick;
  logic [10:0]        xc_dec, xc_inc;
  logic [9:0]         y_step;

  always_comb begin
    xc_s    = signed'({2'b00, xc_q});
    yc_s    = signed'({2'b00, yc_q});
    tx_w    = dir[1] ? (xc_s + DX_S) : (xc_s - DX_S);
    ty_w    = dir[0] ? (yc_s - DY_S) : (yc_s + DY_S);
    min_x_w = (tx_w < xc_s) ? tx_w : xc_s;
    apex_w  = min_x_w - HOP_S;
    legal   = (tx_w >= XMIN_S) && (tx_w <= XMAX_S) &&
              (ty_w >= YMIN_S) && (ty_w <= YMAX_S) &&
              (apex_w >= 13'sd0);
  end

  assign tick   = (cnt_q == CNT_MAX);
  assign xc_dec = xc_q - 11'd1;
  assign xc_inc = xc_q + 11'd1;
  assign y_step = (ty_q < yc_q) ? (yc_q - 10'd1) : (yc_q + 10'd1);

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    apex_d  = apex_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    jump_d  = jump_q;
    done_d  = done_q;
    ack_d   = 1'b0;
    rej_d   = 1'b0;
    land_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load) begin
          // A simultaneous request is dropped silently.
          xc_d = start_xy[20:10];
          yc_d = start_xy[9:0];
        end else if (req) begin
          if (legal) begin
            tx_d    = tx_w[10:0];
            ty_d    = ty_w[9:0];
            apex_d  = apex_w[10:0];
            ack_d   = 1'b1;
            jump_d  = 1'b1;
            done_d  = 1'b0;
            state_d = RISE;
          end else begin
            rej_d = 1'b1;
          end
        end
      end

      RISE: begin
        if (xc_q == apex_q) begin
          state_d = SHIFT;
        end else if (tick) begin
          xc_d = xc_dec;
          if (xc_dec == apex_q) state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (yc_q == ty_q) begin
          state_d = FALL;
        end else if (tick) begin
          yc_d = y_step;
          if (y_step == ty_q) state_d = FALL;
        end
      end

      FALL: begin
        if (xc_q == tx_q) begin
          state_d = LAND;
          land_d  = 1'b1;
        end else if (tick) begin
          xc_d = xc_inc;
          if (xc_inc == tx_q) begin
            state_d = LAND;
            land_d  = 1'b1;
          end
        end
      end

      LAND: begin
        jump_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      xc_q    <= RESET_XY[20:10];
      yc_q    <= RESET_XY[9:0];
      tx_q    <= '0;
      ty_q    <= '0;
      apex_q  <= '0;
      cnt_q   <= '0;
      jump_q  <= 1'b0;
      done_q  <= 1'b1;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
      land_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      apex_q  <= apex_d;
      cnt_q   <= cnt_d;
      jump_q  <= jump_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rej_q   <= rej_d;
      land_q  <= land_d;
    end
  end

  assign xy_pos     = {xc_q, yc_q};
  assign jump       = jump_q;
  assign done_move  = done_q;
  assign req_ack    = ack_q;
  assign req_reject = rej_q;
  assign land       = land_q;

endmodule

// File: tb/tb_qbert_jump_engine.sv
// -----------------------------------------------------------------------------
// Testbench for qbert_jump_engine with a small-scale parameter set.
// A path model (start -> apex -> lateral -> target, one pixel per tick) gives
// the expected outputs every cycle; directed literal checks pin that model.
// -----------------------------------------------------------------------------
module tb_qbert_jump_engine;

  localparam int SD   = 4;
  localparam int HOP  = 10;
  localparam int DX   = 20;
  localparam int DY   = 10;
  localparam int XMIN = 100;
  localparam int XMAX = 2047;
  localparam int YMIN = 0;
  localparam int YMAX = 1023;
  localparam logic [20:0] RXY = {11'd350, 10'd210};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [20:0] start_xy = '0;
  logic        req = 1'b0;
  logic [1:0]  dir = 2'b00;
  logic [20:0] xy_pos;
  logic        jump, done_move, req_ack, req_reject, land;

  qbert_jump_engine #(
    .STEP_DIV(SD), .HOP_H(HOP), .TILE_DX(DX), .TILE_DY(DY),
    .RESET_XY(RXY), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .start_xy(start_xy),
    .req(req), .dir(dir), .xy_pos(xy_pos), .jump(jump),
    .done_move(done_move), .req_ack(req_ack), .req_reject(req_reject),
    .land(land)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [20:0] pack_xy(input int x, input int y);
    logic [10:0] xv;
    logic [9:0]  yv;
    xv = x[10:0];
    yv = y[9:0];
    return {xv, yv};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // ---------------- behavioural model ----------------
  bit          model_on = 0;
  bit          m_busy = 0;
  int          m_k, m_n, m_x0, m_y0, m_tx, m_ty, m_apex;
  logic [20:0] m_xy;
  bit          m_jump, m_done, m_ack, m_rej, m_land;
  int          cx, cy, ctx, cty, capex;

  // Anchor after t ticks of the current hop.
  function automatic logic [20:0] path_pos(input int t);
    int r, s;
    r = m_x0 - m_apex;
    s = iabs(m_ty - m_y0);
    if (t <= r) return pack_xy(m_x0 - t, m_y0);
    if (t <= r + s) return pack_xy(m_apex, (m_ty > m_y0) ? m_y0 + (t - r) : m_y0 - (t - r));
    return pack_xy(m_apex + (t - r - s), m_ty);
  endfunction

  always @(posedge clk) begin
    m_ack = 0; m_rej = 0; m_land = 0;
    if (!reset) begin
      model_on = 1; m_busy = 0; m_xy = RXY; m_jump = 0; m_done = 1;
    end else if (!m_busy) begin
      if (load) m_xy = start_xy;
      else if (req) begin
        cx = int'(m_xy[20:10]);
        cy = int'(m_xy[9:0]);
        ctx = dir[1] ? cx + DX : cx - DX;
        cty = dir[0] ? cy - DY : cy + DY;
        capex = ((ctx < cx) ? ctx : cx) - HOP;
        if (ctx < XMIN || ctx > XMAX || cty < YMIN || cty > YMAX || capex < 0) m_rej = 1;
        else begin
          m_x0 = cx; m_y0 = cy; m_tx = ctx; m_ty = cty; m_apex = capex;
          m_n = (cx - capex) + iabs(cty - cy) + (ctx - capex);
          m_busy = 1; m_k = 0; m_ack = 1; m_jump = 1; m_done = 0;
        end
      end
    end else begin
      m_k++;
      if (m_k > m_n * SD) begin
        m_busy = 0; m_jump = 0; m_done = 1;
      end else begin
        m_xy   = path_pos(m_k / SD);
        m_land = (m_k == m_n * SD);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_xy_pos", xy_pos, m_xy);
      check("m_jump", jump, m_jump);
      check("m_done_move", done_move, m_done);
      check("m_req_ack", req_ack, m_ack);
      check("m_req_reject", req_reject, m_rej);
      check("m_land", land, m_land);
    end
  end

  // Cube colour consumer: one advance per jump-then-done_move event.
  int cube_idx  = 0;
  bit seen_jump = 0;
  always @(negedge clk) begin
    if (model_on) begin
      if (jump) seen_jump = 1;
      else if (seen_jump && done_move) begin
        seen_jump = 0;
        cube_idx  = (cube_idx + 1) % 5;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load_xy(input logic [20:0] v);
    start_xy = v; load = 1;
    @(negedge clk);
    load = 0;
    check("load_xy", xy_pos, v);
  endtask

  task automatic do_hop(input logic [1:0] d, input logic [20:0] exp_xy,
                        input string name, input int inject_at);
    int cnt = 0;
    int lands = 0;
    logic [20:0] land_xy = '0;
    dir = d; req = 1;
    @(negedge clk);
    req = 0;
    check({name, "_ack"}, req_ack, 1);
    while (jump === 1'b1 && cnt < 1000) begin
      if (land === 1'b1) begin lands++; land_xy = xy_pos; end
      req = (cnt == inject_at);
      cnt++;
      @(negedge clk);
    end
    req = 0;
    check({name, "_jump_cycles"}, cnt, 201);
    check({name, "_land_xy"}, land_xy, exp_xy);
    check({name, "_land_count"}, lands, 1);
    check({name, "_done_after"}, done_move, 1);
  endtask

  int exp_idx [6] = '{1, 2, 3, 4, 0, 1};

  initial begin
    reset = 0;
    repeat (2) @(negedge clk);
    check("rst_xy", xy_pos, RXY);
    check("rst_jump", jump, 0);
    check("rst_done", done_move, 1);
    check("rst_pulses", {req_ack, req_reject, land}, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    do_hop(2'b10, pack_xy(370, 220), "down_right", -1);

    load_xy(RXY);
    do_hop(2'b01, pack_xy(330, 200), "up_left", -1);

    // Target x = 90 is below the field.
    load_xy(pack_xy(110, 210));
    dir = 2'b00; req = 1;
    @(negedge clk);
    req = 0;
    check("rej_pulse", req_reject, 1);
    check("rej_no_ack", req_ack, 0);
    check("rej_jump", jump, 0);
    check("rej_done", done_move, 1);
    check("rej_xy", xy_pos, pack_xy(110, 210));
    @(negedge clk);
    check("rej_pulse_end", req_reject, 0);

    // Load wins over a simultaneous request.
    start_xy = RXY; load = 1; req = 1; dir = 2'b10;
    @(negedge clk);
    load = 0; req = 0;
    check("coll_xy", xy_pos, RXY);
    check("coll_no_ack", req_ack, 0);
    check("coll_no_jump", jump, 0);
    @(negedge clk);
    check("coll_still_idle", jump, 0);

    // Request injected mid-SHIFT is ignored.
    do_hop(2'b10, pack_xy(370, 220), "shift_req", 60);
    repeat (3) @(negedge clk);
    check("shift_req_no_rehop", jump, 0);

    // Reset after 5 ticks of RISE.
    load_xy(pack_xy(400, 300));
    dir = 2'b10; req = 1;
    @(negedge clk);
    req = 0;
    repeat (21) @(negedge clk);
    check("mid_rise_xy", xy_pos, pack_xy(395, 300));
    reset = 0;
    @(negedge clk);
    reset = 1;
    check("mid_rst_xy", xy_pos, RXY);
    check("mid_rst_jump", jump, 0);
    check("mid_rst_done", done_move, 1);
    do_hop(2'b10, pack_xy(370, 220), "after_rst", -1);

    // Six hops drive the cube colour index.
    load_xy(RXY);
    @(negedge clk);
    cube_idx = 0; seen_jump = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) do_hop(2'b10, pack_xy(370, 220), "cube_dr", -1);
      else            do_hop(2'b01, pack_xy(350, 210), "cube_ul", -1);
      @(negedge clk);
      check("cube_idx", cube_idx, exp_idx[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
